// File: rtl/lstm_pkg.sv
// Shared fixed-point helpers for the LSTM cell-update pipeline.
// All arithmetic helpers operate on a wide signed container; callers narrow the result.
package lstm_pkg;

   localparam int LSTM_DATA_W = 16;
   localparam int LSTM_FRAC_W = 12;
   localparam int WIDE_W      = 64;
   localparam int ONE         = 1 << LSTM_FRAC_W;

   typedef logic signed [LSTM_DATA_W-1:0] lane_t;
   typedef logic signed [WIDE_W-1:0]      wide_t;

   // Rescale a product back to FRAC_W fraction bits, rounding half toward +inf.
   function automatic wide_t rs_f(input wide_t x, input int frac_w);
      wide_t half;
      half = wide_t'(1) <<< (frac_w - 1);
      return (x + half) >>> frac_w;
   endfunction

   function automatic wide_t sat_f(input wide_t x, input int data_w);
      wide_t hi;
      wide_t lo;
      wide_t r;
      hi = (wide_t'(1) <<< (data_w - 1)) - wide_t'(1);
      lo = -(wide_t'(1) <<< (data_w - 1));
      r  = x;
      if (x > hi) begin
         r = hi;
      end else if (x < lo) begin
         r = lo;
      end
      return r;
   endfunction

   function automatic wide_t hard_tanh_f(input wide_t x, input int frac_w);
      wide_t one_v;
      wide_t r;
      one_v = wide_t'(1) <<< frac_w;
      r     = x;
      if (x > one_v) begin
         r = one_v;
      end else if (x < -one_v) begin
         r = -one_v;
      end
      return r;
   endfunction

endpackage

// File: rtl/lstm_pipe_reg.sv
// Generic elastic register slice: one beat of storage with valid/ready on both sides.
module lstm_pipe_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_data
);

   // Handshake: a beat crosses a boundary on a cycle where valid && ready are both high.
   // The slice loads whenever it is empty or its current beat leaves this cycle, so
   // ready ripples combinationally upstream and bubbles are squeezed out.
   logic             r_valid;
   logic [WIDTH-1:0] r_data;
   logic             w_load;

   assign w_load  = !r_valid || i_ready;
   assign o_ready = w_load;
   assign o_valid = r_valid;
   assign o_data  = r_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (w_load) begin
         r_valid <= i_valid;
         if (i_valid) begin
            r_data <= i_data;
         end
      end
   end

endmodule

// File: rtl/lstm_cell_pipe.sv
// Four-stage elastic LSTM cell update: c' = sat(f*c + i*g), h = sat(o*tanh(c')).
// Each stage is an lstm_pipe_reg slice; per-lane arithmetic sits between the slices.
module lstm_cell_pipe
   import lstm_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int FRAC_W    = 12,
   parameter int LANES     = 4,
   parameter int TAG_W     = 8,
   parameter int TANH_MODE = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_first,
   input  logic [TAG_W-1:0]        in_tag,
   input  logic [LANES*DATA_W-1:0] in_i,
   input  logic [LANES*DATA_W-1:0] in_f,
   input  logic [LANES*DATA_W-1:0] in_g,
   input  logic [LANES*DATA_W-1:0] in_o,
   input  logic [LANES*DATA_W-1:0] in_c,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [TAG_W-1:0]        out_tag,
   output logic [LANES*DATA_W-1:0] out_c,
   output logic [LANES*DATA_W-1:0] out_h,
   output logic                    busy,
   output logic                    sat_flag,
   input  logic                    sat_clr
);

   localparam int PW   = 2 * DATA_W;
   localparam int L1   = 2 * PW + DATA_W;
   localparam int L2   = 2 * DATA_W;
   localparam int L3   = DATA_W + PW;
   localparam int L4   = 2 * DATA_W;
   localparam int S1_W = LANES * L1 + TAG_W;
   localparam int S2_W = LANES * L2 + TAG_W;
   localparam int S3_W = LANES * L3 + TAG_W;
   localparam int S4_W = LANES * L4 + TAG_W;

   logic             w_rdy1, w_rdy2, w_rdy3, w_rdy4;
   logic             w_v1, w_v2, w_v3, w_v4;
   logic [S1_W-1:0]  w_s1_d, w_s1_q;
   logic [S2_W-1:0]  w_s2_d, w_s2_q;
   logic [S3_W-1:0]  w_s3_d, w_s3_q;
   logic [S4_W-1:0]  w_s4_d, w_s4_q;
   logic [LANES-1:0] w_sat2, w_sat4;
   logic             w_sat_set;
   logic             r_sat;

   lstm_pipe_reg #(.WIDTH(S1_W)) u_s1 (
      .clk     (clk),
      .rst     (rst),
      .i_valid (in_valid),
      .o_ready (w_rdy1),
      .i_data  (w_s1_d),
      .o_valid (w_v1),
      .i_ready (w_rdy2),
      .o_data  (w_s1_q)
   );

   lstm_pipe_reg #(.WIDTH(S2_W)) u_s2 (
      .clk     (clk),
      .rst     (rst),
      .i_valid (w_v1),
      .o_ready (w_rdy2),
      .i_data  (w_s2_d),
      .o_valid (w_v2),
      .i_ready (w_rdy3),
      .o_data  (w_s2_q)
   );

   lstm_pipe_reg #(.WIDTH(S3_W)) u_s3 (
      .clk     (clk),
      .rst     (rst),
      .i_valid (w_v2),
      .o_ready (w_rdy3),
      .i_data  (w_s3_d),
      .o_valid (w_v3),
      .i_ready (w_rdy4),
      .o_data  (w_s3_q)
   );

   lstm_pipe_reg #(.WIDTH(S4_W)) u_s4 (
      .clk     (clk),
      .rst     (rst),
      .i_valid (w_v3),
      .o_ready (w_rdy4),
      .i_data  (w_s4_d),
      .o_valid (w_v4),
      .i_ready (out_ready),
      .o_data  (w_s4_q)
   );

   assign in_ready  = w_rdy1;
   assign out_valid = w_v4;
   assign busy      = w_v1 | w_v2 | w_v3 | w_v4;

   // The tag rides in the top bits of every stage word, untouched.
   assign w_s1_d[LANES*L1 +: TAG_W] = in_tag;
   assign w_s2_d[LANES*L2 +: TAG_W] = w_s1_q[LANES*L1 +: TAG_W];
   assign w_s3_d[LANES*L3 +: TAG_W] = w_s2_q[LANES*L2 +: TAG_W];
   assign w_s4_d[LANES*L4 +: TAG_W] = w_s3_q[LANES*L3 +: TAG_W];
   assign out_tag                   = w_s4_q[LANES*L4 +: TAG_W];

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic signed [DATA_W-1:0] w_i, w_f, w_g, w_o, w_c;
      logic signed [PW-1:0]     w_pf, w_pi;
      logic signed [PW-1:0]     w_pf_q, w_pi_q;
      logic signed [DATA_W-1:0] w_o_q1;
      wide_t                    w_sum;
      logic signed [DATA_W-1:0] w_cn;
      logic signed [DATA_W-1:0] w_c_q2, w_o_q2, w_t;
      logic signed [PW-1:0]     w_ph;
      logic signed [DATA_W-1:0] w_c_q3;
      logic signed [PW-1:0]     w_ph_q;
      wide_t                    w_hr;
      logic signed [DATA_W-1:0] w_h;

      // Stage 1: full-precision products; a first timestep starts from c = 0.
      assign w_i  = in_i[k*DATA_W +: DATA_W];
      assign w_f  = in_f[k*DATA_W +: DATA_W];
      assign w_g  = in_g[k*DATA_W +: DATA_W];
      assign w_o  = in_o[k*DATA_W +: DATA_W];
      assign w_c  = in_first ? '0 : in_c[k*DATA_W +: DATA_W];
      assign w_pf = PW'(w_f) * PW'(w_c);
      assign w_pi = PW'(w_i) * PW'(w_g);

      assign w_s1_d[k*L1 +: PW]          = w_pf;
      assign w_s1_d[k*L1 + PW +: PW]     = w_pi;
      assign w_s1_d[k*L1 + 2*PW +: DATA_W] = w_o;

      // Stage 2: rescale both products, add wide so the sum never wraps, then clamp.
      assign w_pf_q    = w_s1_q[k*L1 +: PW];
      assign w_pi_q    = w_s1_q[k*L1 + PW +: PW];
      assign w_o_q1    = w_s1_q[k*L1 + 2*PW +: DATA_W];
      assign w_sum     = rs_f(wide_t'(w_pf_q), FRAC_W) + rs_f(wide_t'(w_pi_q), FRAC_W);
      assign w_cn      = DATA_W'(sat_f(w_sum, DATA_W));
      assign w_sat2[k] = (wide_t'(w_cn) != w_sum);

      assign w_s2_d[k*L2 +: DATA_W]          = w_cn;
      assign w_s2_d[k*L2 + DATA_W +: DATA_W] = w_o_q1;

      // Stage 3: squash c' and multiply by the output gate.
      assign w_c_q2 = w_s2_q[k*L2 +: DATA_W];
      assign w_o_q2 = w_s2_q[k*L2 + DATA_W +: DATA_W];
      assign w_t    = (TANH_MODE != 0) ? w_c_q2
                                       : DATA_W'(hard_tanh_f(wide_t'(w_c_q2), FRAC_W));
      assign w_ph   = PW'(w_o_q2) * PW'(w_t);

      assign w_s3_d[k*L3 +: DATA_W]      = w_c_q2;
      assign w_s3_d[k*L3 + DATA_W +: PW] = w_ph;

      // Stage 4: rescale and clamp h.
      assign w_c_q3    = w_s3_q[k*L3 +: DATA_W];
      assign w_ph_q    = w_s3_q[k*L3 + DATA_W +: PW];
      assign w_hr      = rs_f(wide_t'(w_ph_q), FRAC_W);
      assign w_h       = DATA_W'(sat_f(w_hr, DATA_W));
      assign w_sat4[k] = (wide_t'(w_h) != w_hr);

      assign w_s4_d[k*L4 +: DATA_W]          = w_c_q3;
      assign w_s4_d[k*L4 + DATA_W +: DATA_W] = w_h;

      assign out_c[k*DATA_W +: DATA_W] = w_s4_q[k*L4 +: DATA_W];
      assign out_h[k*DATA_W +: DATA_W] = w_s4_q[k*L4 + DATA_W +: DATA_W];
   end

   // Saturation only counts on a beat that actually moves into the next slice.
   assign w_sat_set = (w_v1 && w_rdy2 && (|w_sat2)) || (w_v3 && w_rdy4 && (|w_sat4));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sat <= 1'b0;
      end else if (sat_clr) begin
         r_sat <= 1'b0;
      end else if (w_sat_set) begin
         r_sat <= 1'b1;
      end
   end

   assign sat_flag = r_sat;

endmodule
